// File: rtl/axis_um_bridge.sv
// axis_um_bridge: AXI-Stream <-> FAST packet bridge with a TX FIFO toward pktin
// and an RX FIFO from pktout that drops the remainder of a packet on overflow.
module axis_um_bridge #(
    parameter int DATA_W       = 256,
    parameter int USER_W       = 128,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16,
    parameter int RX_AF_MARGIN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   tx_axis_tdata,
    input  logic [DATA_W/8-1:0] tx_axis_tkeep,
    input  logic [USER_W-1:0]   tx_axis_tuser,
    input  logic                tx_axis_tlast,
    input  logic                tx_axis_tvalid,
    output logic                tx_axis_tready,
    output logic [DATA_W-1:0]   pktin_data,
    output logic [DATA_W/8-1:0] pktin_keep,
    output logic [USER_W-1:0]   pktin_user,
    output logic                pktin_data_wr,
    output logic                pktin_data_valid,
    output logic                pktin_data_valid_wr,
    input  logic                pktin_ready,
    input  logic [DATA_W-1:0]   pktout_data,
    input  logic [DATA_W/8-1:0] pktout_keep,
    input  logic [USER_W-1:0]   pktout_user,
    input  logic                pktout_data_wr,
    input  logic                pktout_data_valid,
    input  logic                pktout_data_valid_wr,
    output logic                pktout_ready,
    output logic [DATA_W-1:0]   rx_axis_tdata,
    output logic [DATA_W/8-1:0] rx_axis_tkeep,
    output logic [USER_W-1:0]   rx_axis_tuser,
    output logic                rx_axis_tlast,
    output logic                rx_axis_tvalid,
    input  logic                rx_axis_tready,
    output logic [31:0]         tx_pkt_cnt,
    output logic [31:0]         rx_pkt_cnt,
    output logic [31:0]         rx_drop_cnt,
    output logic                rx_ovf
);
    localparam int KW  = DATA_W / 8;
    localparam int BW  = DATA_W + KW + USER_W + 1;
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, PASS, DROP} rx_state_t;

    logic [BW-1:0] tx_mem [TX_DEPTH];
    logic [TAW:0]  tx_wp, tx_rp, tx_used, tx_used_n;
    logic [BW-1:0] tx_head;
    logic          tx_push, tx_pop;

    assign tx_used   = tx_wp - tx_rp;
    assign tx_push   = tx_axis_tvalid & tx_axis_tready;
    assign tx_pop    = (tx_used != '0) & pktin_ready;
    assign tx_used_n = tx_used + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
    assign tx_head   = tx_mem[tx_rp[TAW-1:0]];

    always_ff @(posedge clk)
        if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= {tx_axis_tdata, tx_axis_tkeep, tx_axis_tuser, tx_axis_tlast};

    // tready is registered from next occupancy, so a same-cycle pop frees the slot one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp               <= '0;
            tx_rp               <= '0;
            tx_axis_tready      <= 1'b0;
            pktin_data          <= '0;
            pktin_keep          <= '0;
            pktin_user          <= '0;
            pktin_data_wr       <= 1'b0;
            pktin_data_valid    <= 1'b0;
            pktin_data_valid_wr <= 1'b0;
            tx_pkt_cnt          <= '0;
        end else begin
            tx_wp               <= tx_wp + (TAW+1)'(tx_push);
            tx_rp               <= tx_rp + (TAW+1)'(tx_pop);
            tx_axis_tready      <= tx_used_n != (TAW+1)'(TX_DEPTH);
            pktin_data_wr       <= tx_pop;
            pktin_data_valid    <= tx_pop & tx_head[0];
            pktin_data_valid_wr <= tx_pop & tx_head[0];
            if (tx_pop) {pktin_data, pktin_keep, pktin_user} <= tx_head[BW-1:1];
            tx_pkt_cnt          <= tx_pkt_cnt + 32'(tx_pop & tx_head[0]);
        end
    end

    logic [BW-1:0] rx_mem [RX_DEPTH];
    logic [RAW:0]  rx_wp, rx_rp, rx_used, rx_used_n;
    logic          rx_full, rx_eop, rx_wr, rx_ovfl, rx_pop;
    rx_state_t     rx_state;

    assign rx_used   = rx_wp - rx_rp;
    assign rx_full   = rx_used == (RAW+1)'(RX_DEPTH);
    assign rx_eop    = pktout_data_valid_wr & pktout_data_valid;
    assign rx_wr     = pktout_data_wr & ~rx_full & (rx_state != DROP);
    assign rx_ovfl   = pktout_data_wr & rx_full & (rx_state != DROP);
    assign rx_pop    = rx_axis_tvalid & rx_axis_tready;
    assign rx_used_n = rx_used + (RAW+1)'(rx_wr) - (RAW+1)'(rx_pop);
    assign rx_axis_tvalid = rx_used != '0;
    assign {rx_axis_tdata, rx_axis_tkeep, rx_axis_tuser, rx_axis_tlast} = rx_mem[rx_rp[RAW-1:0]];

    always_ff @(posedge clk)
        if (rx_wr) rx_mem[rx_wp[RAW-1:0]] <= {pktout_data, pktout_keep, pktout_user, rx_eop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp        <= '0;
            rx_rp        <= '0;
            rx_state     <= IDLE;
            pktout_ready <= 1'b0;
            rx_pkt_cnt   <= '0;
            rx_drop_cnt  <= '0;
            rx_ovf       <= 1'b0;
        end else begin
            rx_wp        <= rx_wp + (RAW+1)'(rx_wr);
            rx_rp        <= rx_rp + (RAW+1)'(rx_pop);
            rx_state     <= !pktout_data_wr ? rx_state :
                            rx_eop ? IDLE :
                            (rx_state == DROP || rx_full) ? DROP : PASS;
            pktout_ready <= rx_used_n <= (RAW+1)'(RX_DEPTH - RX_AF_MARGIN);
            rx_pkt_cnt   <= rx_pkt_cnt + 32'(rx_wr & rx_eop);
            rx_drop_cnt  <= rx_drop_cnt + 32'(rx_ovfl);
            rx_ovf       <= rx_ovf | rx_ovfl;
        end
    end
endmodule

// File: tb/tb_axis_um_bridge.sv
// tb_axis_um_bridge: directed + randomized checks of axis_um_bridge against a queue-based model.
module tb_axis_um_bridge;
    localparam int DW = 64, UW = 16, KW = DW / 8, TXD = 16, RXD = 16, MARGIN = 4;

    logic clk = 0, rst_n = 0;
    logic [DW-1:0] tx_axis_tdata = '0, pktin_data, pktout_data = '0, rx_axis_tdata;
    logic [KW-1:0] tx_axis_tkeep = '0, pktin_keep, pktout_keep = '0, rx_axis_tkeep;
    logic [UW-1:0] tx_axis_tuser = '0, pktin_user, pktout_user = '0, rx_axis_tuser;
    logic tx_axis_tlast = 0, tx_axis_tvalid = 0, tx_axis_tready;
    logic pktin_data_wr, pktin_data_valid, pktin_data_valid_wr, pktin_ready = 0;
    logic pktout_data_wr = 0, pktout_data_valid = 0, pktout_data_valid_wr = 0, pktout_ready;
    logic rx_axis_tlast, rx_axis_tvalid, rx_axis_tready = 0;
    logic [31:0] tx_pkt_cnt, rx_pkt_cnt, rx_drop_cnt;
    logic rx_ovf;

    axis_um_bridge #(.DATA_W(DW), .USER_W(UW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .RX_AF_MARGIN(MARGIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep), .tx_axis_tuser(tx_axis_tuser),
        .tx_axis_tlast(tx_axis_tlast), .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tready(tx_axis_tready),
        .pktin_data(pktin_data), .pktin_keep(pktin_keep), .pktin_user(pktin_user),
        .pktin_data_wr(pktin_data_wr), .pktin_data_valid(pktin_data_valid),
        .pktin_data_valid_wr(pktin_data_valid_wr), .pktin_ready(pktin_ready),
        .pktout_data(pktout_data), .pktout_keep(pktout_keep), .pktout_user(pktout_user),
        .pktout_data_wr(pktout_data_wr), .pktout_data_valid(pktout_data_valid),
        .pktout_data_valid_wr(pktout_data_valid_wr), .pktout_ready(pktout_ready),
        .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tuser(rx_axis_tuser),
        .rx_axis_tlast(rx_axis_tlast), .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tready(rx_axis_tready),
        .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .rx_drop_cnt(rx_drop_cnt), .rx_ovf(rx_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    int total = 0, bad = 0;
    int wr_pulses = 0, eop_pulses = 0, rx_hs = 0, rx_lasts = 0;
    bit chk_en = 0, rnd_done = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: packets as queues, the RX policy as a single "dropping" flag
    beat_t txq[$], rxq[$];
    beat_t e_pk = '0;
    logic e_tready = 0, e_pwr = 0, e_pv = 0, e_pready = 0, m_ovf = 0, dropping = 0;
    logic [31:0] m_txcnt = 0, m_rxcnt = 0, m_drop = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            txq.delete(); rxq.delete();
            e_pk = '0; e_tready = 0; e_pwr = 0; e_pv = 0; e_pready = 0;
            m_ovf = 0; dropping = 0; m_txcnt = 0; m_rxcnt = 0; m_drop = 0;
        end else begin
            bit push, full, pop, wr, eop;
            beat_t nb;
            push = tx_axis_tvalid && e_tready;
            if (txq.size() > 0 && pktin_ready) begin
                e_pk = txq.pop_front(); e_pwr = 1; e_pv = e_pk.l;
                if (e_pk.l) m_txcnt++;
            end else begin
                e_pwr = 0; e_pv = 0;
            end
            if (push) txq.push_back({tx_axis_tdata, tx_axis_tkeep, tx_axis_tuser, tx_axis_tlast});
            e_tready = txq.size() < TXD;
            full = rxq.size() == RXD;
            pop = rxq.size() > 0 && rx_axis_tready;
            wr = 0;
            eop = pktout_data_valid_wr && pktout_data_valid;
            nb = {pktout_data, pktout_keep, pktout_user, eop};
            if (pktout_data_wr) begin
                if (dropping) dropping = !eop;
                else if (full) begin m_drop++; m_ovf = 1; dropping = !eop; end
                else begin wr = 1; if (eop) m_rxcnt++; end
            end
            if (pop) void'(rxq.pop_front());
            if (wr) rxq.push_back(nb);
            e_pready = (RXD - rxq.size()) >= MARGIN;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("tx_tready", tx_axis_tready, e_tready);
            chk("pktin_wr", pktin_data_wr, e_pwr);
            chk("pktin_valid", pktin_data_valid, e_pv);
            chk("pktin_valid_wr", pktin_data_valid_wr, e_pv);
            if (e_pwr) chk("pktin_beat", {pktin_data, pktin_keep, pktin_user}, {e_pk.d, e_pk.k, e_pk.u});
            chk("pktout_ready", pktout_ready, e_pready);
            chk("rx_tvalid", rx_axis_tvalid, rxq.size() > 0);
            if (rxq.size() > 0) chk("rx_beat", {rx_axis_tdata, rx_axis_tkeep, rx_axis_tuser, rx_axis_tlast}, rxq[0]);
            chk("tx_pkt_cnt", tx_pkt_cnt, m_txcnt);
            chk("rx_pkt_cnt", rx_pkt_cnt, m_rxcnt);
            chk("rx_drop_cnt", rx_drop_cnt, m_drop);
            chk("rx_ovf", rx_ovf, m_ovf);
        end
        wr_pulses += int'(pktin_data_wr);
        eop_pulses += int'(pktin_data_valid_wr);
        rx_hs += int'(rx_axis_tvalid & rx_axis_tready);
        rx_lasts += int'(rx_axis_tvalid & rx_axis_tready & rx_axis_tlast);
    end

    task automatic tx_send(int n);
        for (int i = 0; i < n; i++) begin
            bit ok = 0;
            tx_axis_tvalid = 1;
            tx_axis_tdata = {$urandom, $urandom};
            tx_axis_tkeep = KW'($urandom);
            tx_axis_tuser = UW'($urandom);
            tx_axis_tlast = (i == n - 1);
            for (int t = 0; t < 500 && !ok; t++) begin
                ok = tx_axis_tready;
                @(negedge clk);
            end
            if (!ok) chk("tx_accept_timeout", 0, 1);
        end
        tx_axis_tvalid = 0;
        tx_axis_tlast = 0;
    endtask

    task automatic rx_send(int n, bit respect);
        for (int i = 0; i < n; i++) begin
            if (respect) begin
                int t = 0;
                pktout_data_wr = 0;
                while (!pktout_ready && t < 500) begin @(negedge clk); t++; end
                if (t == 500) chk("rx_ready_timeout", 0, 1);
            end
            pktout_data_wr = 1;
            pktout_data = {$urandom, $urandom};
            pktout_keep = KW'($urandom);
            pktout_user = UW'($urandom);
            pktout_data_valid_wr = (i == n - 1);
            pktout_data_valid = (i == n - 1) ? 1'b1 : 1'($urandom);
            @(negedge clk);
        end
        pktout_data_wr = 0;
        pktout_data_valid = 0;
        pktout_data_valid_wr = 0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_tready", tx_axis_tready, 0);
        chk("rst_pready", pktout_ready, 0);
        chk("rst_rx_tvalid", rx_axis_tvalid, 0);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_tready", tx_axis_tready, 1);
        chk("post_rst_pready", pktout_ready, 1);

        pktin_ready = 1;
        wr_pulses = 0; eop_pulses = 0;
        tx_send(3);
        idle(3);
        chk("t026_wr_pulses", wr_pulses, 3);
        chk("t026_eop_pulses", eop_pulses, 1);
        chk("t026_tx_pkt_cnt", tx_pkt_cnt, 1);

        pktin_ready = 0;
        wr_pulses = 0;
        tx_send(16);
        chk("t027_full_tready", tx_axis_tready, 0);
        pktin_ready = 1;
        idle(20);
        chk("t027_wr_pulses", wr_pulses, 16);
        chk("t027_tready_back", tx_axis_tready, 1);
        chk("t027_tx_pkt_cnt", tx_pkt_cnt, 2);

        rx_axis_tready = 1;
        rx_hs = 0; rx_lasts = 0;
        rx_send(2, 0);
        idle(4);
        chk("t028_rx_hs", rx_hs, 2);
        chk("t028_rx_last", rx_lasts, 1);
        chk("t028_rx_pkt_cnt", rx_pkt_cnt, 1);

        rx_axis_tready = 0;
        rx_send(20, 0);
        chk("t029_pready_low", pktout_ready, 0);
        chk("t029_drop_cnt", rx_drop_cnt, 1);
        chk("t029_ovf", rx_ovf, 1);
        chk("t029_rx_pkt_cnt", rx_pkt_cnt, 1);
        rx_axis_tready = 1;
        idle(20);
        rx_send(2, 1);
        idle(6);
        chk("t029_next_pkt", rx_pkt_cnt, 2);
        chk("t029_pready_back", pktout_ready, 1);

        pktin_ready = 0;
        rx_axis_tready = 0;
        tx_axis_tvalid = 1; tx_axis_tlast = 0; tx_axis_tdata = {$urandom, $urandom};
        pktout_data_wr = 1; pktout_data_valid = 0; pktout_data_valid_wr = 0;
        idle(2);
        #2 rst_n = 0;
        #1;
        chk("t030_tready", tx_axis_tready, 0);
        chk("t030_pin_wr", pktin_data_wr, 0);
        chk("t030_pin_v", pktin_data_valid, 0);
        chk("t030_pin_vwr", pktin_data_valid_wr, 0);
        chk("t030_pin_beat", {pktin_data, pktin_keep, pktin_user}, 0);
        chk("t030_pready", pktout_ready, 0);
        chk("t030_rx_tvalid", rx_axis_tvalid, 0);
        chk("t030_counts", {tx_pkt_cnt, rx_pkt_cnt, rx_drop_cnt, 31'd0, rx_ovf}, 0);
        tx_axis_tvalid = 0; pktout_data_wr = 0;
        idle(2);
        rst_n = 1;
        @(negedge clk);
        chk("t030_post_tready", tx_axis_tready, 1);
        chk("t030_post_pready", pktout_ready, 1);
        pktin_ready = 1; rx_axis_tready = 1;
        tx_send(1);
        rx_send(1, 0);
        idle(4);
        chk("t030_tx_pkt_cnt", tx_pkt_cnt, 1);
        chk("t030_rx_pkt_cnt", rx_pkt_cnt, 1);
        chk("t030_drop_cnt", rx_drop_cnt, 0);

        fork
            begin
                repeat (40) begin tx_send(int'($urandom_range(1, 6))); idle(int'($urandom_range(0, 3))); end
            end
            begin
                repeat (40) begin rx_send(int'($urandom_range(1, 8)), 1'($urandom_range(0, 1))); idle(int'($urandom_range(0, 3))); end
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    pktin_ready = $urandom_range(0, 3) != 0;
                    rx_axis_tready = $urandom_range(0, 2) != 0;
                end
            end
            begin
                idle(3000);
                rnd_done = 1;
            end
        join_any
        wait (rnd_done);
        pktin_ready = 1; rx_axis_tready = 1;
        idle(60);
        chk("final_rx_empty", rx_axis_tvalid, 0);
        chk("final_tready", tx_axis_tready, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
